// File: rtl/conv_mem_host.sv
// Host-side memory responder for the convolution engine: image load, engine ports, result readout.
// Optional protocol checker with sticky err output is built when CONVMEM_ERRCHK_EN is defined.
module conv_mem_host #(
   parameter int DW     = 20,
   parameter int IMG_AW = 12,
   parameter int L1_AW  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [DW-1:0]     load_data,
   output logic              load_ready,
   output logic              ready,
   input  logic              busy,
   input  logic [IMG_AW-1:0] iaddr,
   output logic [DW-1:0]     idata,
   input  logic              cwr,
   input  logic [IMG_AW-1:0] caddr_wr,
   input  logic [DW-1:0]     cdata_wr,
   input  logic              crd,
   input  logic [IMG_AW-1:0] caddr_rd,
   output logic [DW-1:0]     cdata_rd,
   input  logic [2:0]        csel,
   output logic              done,
   input  logic              res_sel,
   input  logic [IMG_AW-1:0] res_addr,
   output logic [DW-1:0]     res_data
`ifdef CONVMEM_ERRCHK_EN
   ,
   output logic              err
`endif
);

   typedef enum logic [2:0] {LOAD, START, WAIT_HI, RUN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [IMG_AW-1:0] cnt_reg, cnt_next;
   logic              load_we;
   logic [IMG_AW-1:0] load_waddr;

   logic [DW-1:0] image_mem  [0:(1<<IMG_AW)-1];
   logic [DW-1:0] layer0_mem [0:(1<<IMG_AW)-1];
   logic [DW-1:0] layer1_mem [0:(1<<L1_AW)-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= LOAD;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load_we    = 1'b0;
      load_waddr = cnt_reg;
      case (state_reg)
         LOAD: begin
            if (load_valid) begin
               load_we  = 1'b1;
               cnt_next = cnt_reg + IMG_AW'(1);
               if (cnt_reg == '1)
                  state_next = START;
            end
         end
         START:   state_next = WAIT_HI;
         WAIT_HI: if (busy)  state_next = RUN;
         RUN:     if (!busy) state_next = DONE;
         DONE: begin
            // A new image can start straight from DONE; its first word lands at address 0.
            if (load_valid) begin
               load_we    = 1'b1;
               load_waddr = '0;
               cnt_next   = IMG_AW'(1);
               state_next = LOAD;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   always_comb begin
      load_ready = (state_reg == LOAD) || (state_reg == DONE);
      ready      = (state_reg == START);
      done       = (state_reg == DONE);
   end

   always_ff @(posedge clk) begin
      if (load_we)
         image_mem[load_waddr] <= load_data;
      if (cwr && csel == 3'd1)
         layer0_mem[caddr_wr] <= cdata_wr;
      if (cwr && csel == 3'd3)
         layer1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
   end

   always_comb begin
      idata = image_mem[iaddr];
      case (csel)
         3'd1:    cdata_rd = layer0_mem[caddr_rd];
         3'd3:    cdata_rd = layer1_mem[caddr_rd[L1_AW-1:0]];
         default: cdata_rd = '0;
      endcase
      res_data = res_sel ? layer1_mem[res_addr[L1_AW-1:0]] : layer0_mem[res_addr];
   end

`ifdef CONVMEM_ERRCHK_EN
   logic bad_access;

   always_comb begin
      bad_access = 1'b0;
      if ((cwr || crd) && !(csel == 3'd1 || csel == 3'd3))
         bad_access = 1'b1;
      if (csel == 3'd3 && cwr && (caddr_wr[IMG_AW-1:L1_AW] != '0))
         bad_access = 1'b1;
      if (csel == 3'd3 && crd && (caddr_rd[IMG_AW-1:L1_AW] != '0))
         bad_access = 1'b1;
      if ((cwr || crd) && !(state_reg == WAIT_HI || state_reg == RUN))
         bad_access = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err <= 1'b0;
      else if (bad_access)
         err <= 1'b1;
   end
`else
   // The read strobe only matters to the checker; data is never gated by it.
   logic unused_inputs;
   assign unused_inputs = crd;
`endif

endmodule

// File: doc/conv_mem_host.md
# conv_mem_host

Host-side responder for the convolution engine's memory interface. It loads a 64x64 20-bit image from a streaming source, starts the engine with a one-cycle `ready` pulse, and serves the engine's image-read, layer-write and layer-read ports until `busy` falls. It then exposes the layer results to a host readout port. It sits between the system/DMA side and the convolution engine, replacing the behavioural test memories with a synthesizable block.

## Interface
- `DW`, 20, data width of image and layer words
- `IMG_AW`, 12, image and layer-0 address width (4096 words)
- `L1_AW`, 10, layer-1 address width (1024 words)
- `clk` input 1: clock
- `reset` input 1: reset, asynchronous, active-high
- `load_valid` input 1: image word present on `load_data`
- `load_data` input DW: image word, raster order, address 0 first
- `load_ready` output 1: block accepts a load word this cycle
- `ready` output 1: start pulse to engine
- `busy` input 1: engine running
- `iaddr` input IMG_AW: engine image read address
- `idata` output DW: image word at `iaddr`
- `cwr` input 1: engine layer write strobe
- `caddr_wr` input 12: layer write address
- `cdata_wr` input DW: layer write data
- `crd` input 1: engine layer read strobe
- `caddr_rd` input 12: layer read address
- `cdata_rd` output DW: layer read data
- `csel` input 3: layer select; 3'd1 = layer 0, 3'd3 = layer 1
- `done` output 1: results valid, engine finished
- `res_sel` input 1: readout bank; 0 = layer 0, 1 = layer 1
- `res_addr` input 12: readout address
- `res_data` output DW: readout word
- `err` output 1: sticky protocol error (only with `CONVMEM_ERRCHK_EN`)

## Operation
- FSM states: `LOAD`, `START`, `WAIT_HI`, `RUN`, `DONE`. Reset enters `LOAD` with the load counter at 0.
- `LOAD`:
  - `load_ready`=1.
  - Each cycle with `load_valid`=1 writes `load_data` to image[cnt] and increments cnt.
  - The write at cnt=4095 moves the FSM to `START`. cnt wraps to 0.
- `START`: `ready`=1 for exactly one cycle, then `WAIT_HI`.
- `WAIT_HI`: waits for `busy`=1, then `RUN`.
- `RUN`: waits for `busy`=0, then `DONE`.
- `DONE`:
  - `done`=1 and `load_ready`=1.
  - A `load_valid` writes image[0], sets cnt=1 and enters `LOAD`. `done` drops in that same cycle.
- `idata`: combinational read of image[`iaddr`], valid in all states.
- Layer writes, any state: on `cwr`=1 at a rising edge, write `cdata_wr` to the bank selected by `csel`.
  - csel=1 writes layer0[`caddr_wr`].
  - csel=3 writes layer1[`caddr_wr[9:0]`].
  - Any other csel: write dropped.
- `cdata_rd`: combinational.
  - csel=1 gives layer0[`caddr_rd`]; csel=3 gives layer1[`caddr_rd[9:0]`].
  - Any other csel gives 0.
  - `crd` does not gate the data.
- Read-during-write to the same bank and address returns the old word. The write lands at the edge.
- `res_data`: combinational read of the bank chosen by `res_sel`. Valid in all states; meaningful when `done`=1.
- Memory arrays have no reset. Reset mid-operation returns the FSM to `LOAD` and clears cnt and flags; array contents are retained.

## Timing
- Reset values: `load_ready`=1, `ready`=0, `done`=0, `err`=0.
- Reset values of combinational outputs: `idata`, `cdata_rd` and `res_data` follow the arrays.
- Latency from the 4096th accepted load word to `ready`=1: 1 cycle.
- `ready` high for exactly 1 cycle.
- `done` rises 1 cycle after the first cycle with `busy`=0 in `RUN`.
- Zero-latency read ports. The engine samples `idata` and `cdata_rd` in the same cycle it drives the address.
- `busy` already low when `WAIT_HI` is entered: keep waiting. There is no timeout.
- `load_valid` in `START`, `WAIT_HI` or `RUN`: ignored, because `load_ready`=0.

## Configuration
- `CONVMEM_ERRCHK_EN` defined:
  - `err` port exists.
  - `err` sets and stays set until reset when any of the following occurs:
    - `cwr`=1 or `crd`=1 with csel not in {1,3};
    - csel=3 with `caddr_wr[11:10]`≠0 on a write, or `caddr_rd[11:10]`≠0 on a read;
    - `cwr`=1 or `crd`=1 outside `WAIT_HI`/`RUN`.
- `CONVMEM_ERRCHK_EN` undefined: no `err` port and no checking logic. All other behaviour is identical.

## Test plan
- Load ramp image[i]=i with `load_valid` held high:
  - `ready` pulses for 1 cycle exactly 1 cycle after word 4095.
  - Then drive `iaddr`=130: `idata`=130.
- Engine model writes csel=1, addr 5, data 20'h12345, then csel=3, addr 1023, data 20'h0ABCD:
  - Reads via `caddr_rd` with matching csel return 20'h12345 and 20'h0ABCD.
  - csel=2 read returns 0.
- `busy` high for 100 cycles, then low: `done`=1 one cycle after the fall.
  - `res_sel`=1, `res_addr`=1023 gives 20'h0ABCD.
- Write csel=3 addr 7 data 9 while reading addr 7 in the same cycle:
  - `cdata_rd` shows the old value that cycle and 9 the next cycle.
- Assert `reset` in `RUN`:
  - `done`=0, `load_ready`=1.
  - Layer0[5] still reads 20'h12345.
  - A fresh 4096-word load produces a new `ready` pulse.
- With `CONVMEM_ERRCHK_EN`:
  - `cwr` with csel=2 sets `err`=1, which stays 1 after subsequent legal traffic.
  - Without the macro, the same stimulus causes no array change and there is no `err` port.
